l1_mem_arbiter: RTL and testbench

- Shares the single main-memory port between the L1 data cache (D side) and the L1 instruction cache (I side).
- Each cache runs the standard L1↔memory burst protocol: VALID/READY connect, address phase, then word and count phases with ACK_DATA and ACK_COUNT, then RESET_ACK.
- The arbiter grants one cache at a time using round-robin and holds the grant for the whole transaction.
- While a grant is held it steers that cache's signals to and from memory; a watchdog aborts any transaction that stalls.

---
 rtl/l1_arb_pkg.sv | 50 +++++
 rtl/arb_watchdog.sv | 55 +++++
 rtl/l1_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_l1_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_arb_pkg.sv
// Shared types and constants for the L1 memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package l1_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_D = 2'd1,
        ST_GRANT_I = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_D    = 2'b01;
    localparam logic [1:0] OWNER_I    = 2'b10;

    localparam logic SIDE_D = 1'b0;
    localparam logic SIDE_I = 1'b1;

    // "No word" marker of the burst protocol; 4'h0 would mean word 0 acknowledged.
    localparam logic [3:0] ACK_IDLE = 4'hF;

    localparam int TIMEOUT_DEF    = 255;
    localparam int TURNAROUND_DEF = 2;

    // Requester-to-memory bundle.
    typedef struct packed {
        logic [31:0] dat;
        logic        ack_addr;
        logic [3:0]  ack_data;
        logic        ack_count;
        logic        reset_ack;
    } l1_side_t;

    // Memory-to-requester bundle.
    typedef struct packed {
        logic        ready;
        logic [31:0] dat;
        logic        ack_addr;
        logic [3:0]  ack_data;
        logic        ack_count;
        logic        reset_ack;
    } mem_side_t;

    localparam l1_side_t L1_IDLE = '{dat: 32'd0, ack_addr: 1'b0, ack_data: ACK_IDLE,
                                     ack_count: 1'b0, reset_ack: 1'b0};
    localparam mem_side_t MEM_IDLE = '{ready: 1'b0, dat: 32'd0, ack_addr: 1'b0, ack_data: ACK_IDLE,
                                       ack_count: 1'b0, reset_ack: 1'b0};

endpackage

// File: rtl/arb_watchdog.sv
// Stall watchdog: counts cycles without handshake activity while a grant is held.
// Latency: expiry is combinational from the registered count (same cycle the count hits TIMEOUT).
// Backpressure: none; observes only. Ports: i_active (grant held), ack inputs to watch, o_expired.
module arb_watchdog
    import l1_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_active,
    input  logic       i_ack_addr_mem,
    input  logic [3:0] i_ack_data_mem,
    input  logic       i_ack_count_mem,
    input  logic [3:0] i_ack_data_l1,
    output logic       o_expired
);

    logic       r_prev_ack_addr_mem;
    logic [3:0] r_prev_ack_data_mem;
    logic       r_prev_ack_count_mem;
    logic [3:0] r_prev_ack_data_l1;
    logic [7:0] r_cnt;
    logic       w_activity;

    assign w_activity = (i_ack_addr_mem  != r_prev_ack_addr_mem)  ||
                        (i_ack_data_mem  != r_prev_ack_data_mem)  ||
                        (i_ack_count_mem != r_prev_ack_count_mem) ||
                        (i_ack_data_l1   != r_prev_ack_data_l1);

    // Activity in the current cycle wins over an expiring count.
    assign o_expired = (TIMEOUT != 0) && i_active && !w_activity && (r_cnt == 8'(TIMEOUT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_ack_addr_mem  <= 1'b0;
            r_prev_ack_data_mem  <= ACK_IDLE;
            r_prev_ack_count_mem <= 1'b0;
            r_prev_ack_data_l1   <= ACK_IDLE;
            r_cnt                <= 8'd0;
        end else begin
            r_prev_ack_addr_mem  <= i_ack_addr_mem;
            r_prev_ack_data_mem  <= i_ack_data_mem;
            r_prev_ack_count_mem <= i_ack_count_mem;
            r_prev_ack_data_l1   <= i_ack_data_l1;
            // Held at zero outside a grant, so every grant starts from a clean count.
            if (!i_active || w_activity) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between L1 D and L1 I caches; routes the granted side.
// Latency: grant one cycle after VALID is sampled; routing is combinational (zero added latency).
// Backpressure: loser waits for the full transaction plus TURNAROUND; MEM_READY forwarded to owner only.
module l1_mem_arbiter
    import l1_arb_pkg::*;
#(
    parameter int TURNAROUND = TURNAROUND_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // D side
    input  logic        i_d_valid,
    output logic        o_d_ready,
    input  logic [31:0] i_d_data_l1,
    output logic [31:0] o_d_data_mem,
    input  logic        i_d_ack_addr_l1,
    output logic        o_d_ack_addr_mem,
    input  logic [3:0]  i_d_ack_data_l1,
    output logic [3:0]  o_d_ack_data_mem,
    input  logic        i_d_ack_count_l1,
    output logic        o_d_ack_count_mem,
    input  logic        i_d_reset_ack_l1,
    output logic        o_d_reset_ack_mem,
    // I side
    input  logic        i_i_valid,
    output logic        o_i_ready,
    input  logic [31:0] i_i_data_l1,
    output logic [31:0] o_i_data_mem,
    input  logic        i_i_ack_addr_l1,
    output logic        o_i_ack_addr_mem,
    input  logic [3:0]  i_i_ack_data_l1,
    output logic [3:0]  o_i_ack_data_mem,
    input  logic        i_i_ack_count_l1,
    output logic        o_i_ack_count_mem,
    input  logic        i_i_reset_ack_l1,
    output logic        o_i_reset_ack_mem,
    // Memory port
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_data_l1,
    output logic        o_mem_ack_addr_l1,
    output logic [3:0]  o_mem_ack_data_l1,
    output logic        o_mem_ack_count_l1,
    output logic        o_mem_reset_ack_l1,
    input  logic [31:0] i_mem_data_mem,
    input  logic        i_mem_ack_addr_mem,
    input  logic [3:0]  i_mem_ack_data_mem,
    input  logic        i_mem_ack_count_mem,
    input  logic        i_mem_reset_ack_mem,
    // Status
    output logic [1:0]  o_owner,
    output logic        o_timeout_err,
    output logic        o_err_owner
);

    arb_state_t r_state;
    logic [1:0] r_owner;
    logic       r_route_side;   // side whose signals are steered (kept through RELEASE)
    logic       r_last_owner;   // round-robin history, updated on normal completion only
    logic [1:0] r_mask;         // indexed by side; set on abort, cleared when that VALID drops
    logic [1:0] r_rel_cnt;
    logic       r_timeout_err;
    logic       r_err_owner;

    l1_side_t   w_d_req, w_i_req, w_sel_req;
    mem_side_t  w_mem_rsp, w_d_rsp, w_i_rsp;
    logic       w_mem_valid;
    logic       w_elig_d, w_elig_i, w_grant_vld, w_grant_side, w_own_valid, w_wd_expired;
    arb_state_t w_grant_state;
    logic [1:0] w_grant_owner;

    assign w_d_req   = '{dat: i_d_data_l1, ack_addr: i_d_ack_addr_l1, ack_data: i_d_ack_data_l1,
                         ack_count: i_d_ack_count_l1, reset_ack: i_d_reset_ack_l1};
    assign w_i_req   = '{dat: i_i_data_l1, ack_addr: i_i_ack_addr_l1, ack_data: i_i_ack_data_l1,
                         ack_count: i_i_ack_count_l1, reset_ack: i_i_reset_ack_l1};
    assign w_mem_rsp = '{ready: i_mem_ready, dat: i_mem_data_mem, ack_addr: i_mem_ack_addr_mem,
                         ack_data: i_mem_ack_data_mem, ack_count: i_mem_ack_count_mem,
                         reset_ack: i_mem_reset_ack_mem};

    // Arbitration; on a tie the side that did not finish last wins.
    assign w_elig_d      = i_d_valid && !r_mask[SIDE_D];
    assign w_elig_i      = i_i_valid && !r_mask[SIDE_I];
    assign w_grant_vld   = w_elig_d || w_elig_i;
    assign w_grant_side  = (w_elig_d && w_elig_i) ? ~r_last_owner : w_elig_i;
    assign w_grant_state = w_grant_side ? ST_GRANT_I : ST_GRANT_D;
    assign w_grant_owner = w_grant_side ? OWNER_I : OWNER_D;
    assign w_own_valid   = r_route_side ? i_i_valid : i_d_valid;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_active        ((r_state == ST_GRANT_D) || (r_state == ST_GRANT_I)),
        .i_ack_addr_mem  (i_mem_ack_addr_mem),
        .i_ack_data_mem  (i_mem_ack_data_mem),
        .i_ack_count_mem (i_mem_ack_count_mem),
        .i_ack_data_l1   (w_sel_req.ack_data),
        .o_expired       (w_wd_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWNER_NONE;
            r_route_side  <= SIDE_D;
            r_last_owner  <= SIDE_I;
            r_mask        <= 2'b00;
            r_rel_cnt     <= 2'd0;
            r_timeout_err <= 1'b0;
            r_err_owner   <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            if (!i_d_valid) r_mask[SIDE_D] <= 1'b0;
            if (!i_i_valid) r_mask[SIDE_I] <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_state      <= w_grant_state;
                        r_route_side <= w_grant_side;
                        r_owner      <= w_grant_owner;
                    end
                end
                ST_GRANT_D, ST_GRANT_I: begin
                    if (!w_own_valid) begin
                        r_state      <= ST_RELEASE;
                        r_owner      <= OWNER_NONE;
                        r_last_owner <= r_route_side;
                        r_rel_cnt    <= 2'd0;
                    end else if (w_wd_expired) begin
                        r_state              <= ST_RELEASE;
                        r_owner              <= OWNER_NONE;
                        r_rel_cnt            <= 2'd0;
                        r_timeout_err        <= 1'b1;
                        r_err_owner          <= r_route_side;
                        r_mask[r_route_side] <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Last turnaround cycle arbitrates directly, so OWNER reads 00 for exactly TURNAROUND cycles.
                    if (r_rel_cnt == 2'(TURNAROUND - 1)) begin
                        if (w_grant_vld) begin
                            r_state      <= w_grant_state;
                            r_route_side <= w_grant_side;
                            r_owner      <= w_grant_owner;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_rel_cnt <= r_rel_cnt + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Steering: route the current/last owner in GRANT and RELEASE; MEM_VALID only while granted.
    always_comb begin
        w_mem_valid = 1'b0;
        w_sel_req   = L1_IDLE;
        w_d_rsp     = MEM_IDLE;
        w_i_rsp     = MEM_IDLE;
        if (r_state != ST_IDLE) begin
            w_sel_req = r_route_side ? w_i_req : w_d_req;
            if (r_route_side) w_i_rsp = w_mem_rsp;
            else              w_d_rsp = w_mem_rsp;
            if (r_state != ST_RELEASE) w_mem_valid = w_own_valid;
        end
    end

    assign o_mem_valid        = w_mem_valid;
    assign o_mem_data_l1      = w_sel_req.dat;
    assign o_mem_ack_addr_l1  = w_sel_req.ack_addr;
    assign o_mem_ack_data_l1  = w_sel_req.ack_data;
    assign o_mem_ack_count_l1 = w_sel_req.ack_count;
    assign o_mem_reset_ack_l1 = w_sel_req.reset_ack;

    assign o_d_ready          = w_d_rsp.ready;
    assign o_d_data_mem       = w_d_rsp.dat;
    assign o_d_ack_addr_mem   = w_d_rsp.ack_addr;
    assign o_d_ack_data_mem   = w_d_rsp.ack_data;
    assign o_d_ack_count_mem  = w_d_rsp.ack_count;
    assign o_d_reset_ack_mem  = w_d_rsp.reset_ack;

    assign o_i_ready          = w_i_rsp.ready;
    assign o_i_data_mem       = w_i_rsp.dat;
    assign o_i_ack_addr_mem   = w_i_rsp.ack_addr;
    assign o_i_ack_data_mem   = w_i_rsp.ack_data;
    assign o_i_ack_count_mem  = w_i_rsp.ack_count;
    assign o_i_reset_ack_mem  = w_i_rsp.reset_ack;

    assign o_owner            = r_owner;
    assign o_timeout_err      = r_timeout_err;
    assign o_err_owner        = r_err_owner;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_l1_mem_arbiter;

    localparam int TO   = 255;
    localparam int TURN = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Index 0 = D side, 1 = I side.
    logic        v[2];
    logic [31:0] dl1[2];
    logic        aal1[2];
    logic [3:0]  adl1[2];
    logic        acl1[2];
    logic        ral1[2];
    logic        rdy_o[2];
    logic [31:0] dmem_o[2];
    logic        aam_o[2];
    logic [3:0]  adm_o[2];
    logic        acm_o[2];
    logic        ram_o[2];

    logic        mem_valid, mem_ready;
    logic [31:0] mem_dl1_o, mem_dmem;
    logic        mem_aal1_o, mem_acl1_o, mem_ral1_o;
    logic [3:0]  mem_adl1_o, mem_adm;
    logic        mem_aam, mem_acm, mem_ram;
    logic [1:0]  owner;
    logic        to_err, err_owner;

    l1_mem_arbiter #(.TURNAROUND(TURN), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_d_valid(v[0]), .o_d_ready(rdy_o[0]), .i_d_data_l1(dl1[0]), .o_d_data_mem(dmem_o[0]),
        .i_d_ack_addr_l1(aal1[0]), .o_d_ack_addr_mem(aam_o[0]), .i_d_ack_data_l1(adl1[0]),
        .o_d_ack_data_mem(adm_o[0]), .i_d_ack_count_l1(acl1[0]), .o_d_ack_count_mem(acm_o[0]),
        .i_d_reset_ack_l1(ral1[0]), .o_d_reset_ack_mem(ram_o[0]),
        .i_i_valid(v[1]), .o_i_ready(rdy_o[1]), .i_i_data_l1(dl1[1]), .o_i_data_mem(dmem_o[1]),
        .i_i_ack_addr_l1(aal1[1]), .o_i_ack_addr_mem(aam_o[1]), .i_i_ack_data_l1(adl1[1]),
        .o_i_ack_data_mem(adm_o[1]), .i_i_ack_count_l1(acl1[1]), .o_i_ack_count_mem(acm_o[1]),
        .i_i_reset_ack_l1(ral1[1]), .o_i_reset_ack_mem(ram_o[1]),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_data_l1(mem_dl1_o),
        .o_mem_ack_addr_l1(mem_aal1_o), .o_mem_ack_data_l1(mem_adl1_o), .o_mem_ack_count_l1(mem_acl1_o),
        .o_mem_reset_ack_l1(mem_ral1_o), .i_mem_data_mem(mem_dmem), .i_mem_ack_addr_mem(mem_aam),
        .i_mem_ack_data_mem(mem_adm), .i_mem_ack_count_mem(mem_acm), .i_mem_reset_ack_mem(mem_ram),
        .o_owner(owner), .o_timeout_err(to_err), .o_err_owner(err_owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = nobody routed, 1 = granted, 2 = turnaround
    int   m_phase, m_side, m_last, m_rel, m_quiet;
    bit   m_mask[2];
    bit   m_err;
    int   m_err_side;
    logic m_prev_aam, m_prev_acm;
    logic [3:0] m_prev_adm, m_prev_adl1;

    localparam logic [39:0] IDLE_VEC = {1'b0, 32'd0, 1'b0, 4'hF, 1'b0, 1'b0};

    function automatic logic [39:0] exp_mem_vec();
        if (m_phase == 0) return IDLE_VEC;
        return {(m_phase == 1) ? v[m_side] : 1'b0, dl1[m_side], aal1[m_side], adl1[m_side],
                acl1[m_side], ral1[m_side]};
    endfunction

    function automatic logic [39:0] exp_rsp_vec(input int k);
        if (m_phase != 0 && m_side == k) return {mem_ready, mem_dmem, mem_aam, mem_adm, mem_acm, mem_ram};
        return IDLE_VEC;
    endfunction

    function automatic logic [1:0] exp_owner();
        if (m_phase != 1) return 2'b00;
        return (m_side == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic m_try_grant();
        bit e0, e1;
        e0 = v[0] && !m_mask[0];
        e1 = v[1] && !m_mask[1];
        if (e0 || e1) begin
            m_phase = 1;
            if (e0 && e1) m_side = (m_last == 0) ? 1 : 0;
            else          m_side = e1 ? 1 : 0;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic model_step();
        logic [39:0] mv;
        bit act, was_grant;
        mv = exp_mem_vec();
        act = (mem_aam != m_prev_aam) || (mem_adm != m_prev_adm) ||
              (mem_acm != m_prev_acm) || (mv[5:2] != m_prev_adl1);
        was_grant = (m_phase == 1);
        m_err = 0;
        if (m_phase == 1) begin
            if (!v[m_side]) begin
                m_phase = 2; m_rel = TURN; m_last = m_side;
            end else if (TO != 0 && !act && m_quiet == TO) begin
                m_phase = 2; m_rel = TURN; m_err = 1; m_err_side = m_side; m_mask[m_side] = 1;
            end
        end else if (m_phase == 2) begin
            m_rel--;
            if (m_rel == 0) m_try_grant();
        end else begin
            m_try_grant();
        end
        for (int k = 0; k < 2; k++) if (!v[k]) m_mask[k] = 0;
        if (!was_grant || act) m_quiet = 0;
        else if (m_quiet < 255) m_quiet++;
        m_prev_aam = mem_aam; m_prev_adm = mem_adm; m_prev_acm = mem_acm; m_prev_adl1 = mv[5:2];
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_side = 0; m_last = 1; m_rel = 0; m_quiet = 0;
            m_mask[0] = 0; m_mask[1] = 0; m_err = 0; m_err_side = 0;
            m_prev_aam = 0; m_prev_adm = 4'hF; m_prev_acm = 0; m_prev_adl1 = 4'hF;
        end else begin
            model_step();
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_owner", owner, exp_owner());
            chk("cyc_mem_side", {mem_valid, mem_dl1_o, mem_aal1_o, mem_adl1_o, mem_acl1_o, mem_ral1_o},
                exp_mem_vec());
            chk("cyc_d_side", {rdy_o[0], dmem_o[0], aam_o[0], adm_o[0], acm_o[0], ram_o[0]}, exp_rsp_vec(0));
            chk("cyc_i_side", {rdy_o[1], dmem_o[1], aam_o[1], adm_o[1], acm_o[1], ram_o[1]}, exp_rsp_vec(1));
            chk("cyc_err", {to_err, err_owner}, {m_err, m_err_side[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_owner_seq(input string name, input logic [1:0] e0, input logic [1:0] e1,
                                 input logic [1:0] e2, input logic [1:0] e3);
        logic [1:0] seq[4];
        seq[0] = e0; seq[1] = e1; seq[2] = e2; seq[3] = e3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(name, owner, seq[i]);
        end
    endtask

    initial begin
        int n;
        int stall_left;
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            v[k] = 0; dl1[k] = 0; aal1[k] = 0; adl1[k] = 4'hF; acl1[k] = 0; ral1[k] = 0;
        end
        mem_ready = 0; mem_dmem = 0; mem_aam = 0; mem_adm = 4'hF; mem_acm = 0; mem_ram = 0;
        chk_en = 1;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_owner", owner, 2'b00);
        chk("rst_d_ack_data", adm_o[0], 4'hF);
        chk("rst_mem_ack_data_l1", mem_adl1_o, 4'hF);
        chk("rst_err", {to_err, err_owner}, 2'b00);
        tick(); rst_n = 1;

        // First conflict after reset: D wins, I follows after turnaround.
        tick(); v[0] = 1; v[1] = 1; dl1[0] = 32'h1000_0040; dl1[1] = 32'h2000_0080;
        @(negedge clk); chk("conflict1_pre", owner, 2'b00);
        @(negedge clk); chk("conflict1_d", owner, 2'b01);
        tick(); tick(); v[0] = 0;
        chk_owner_seq("conflict1_handover", 2'b01, 2'b00, 2'b00, 2'b10);
        tick(); v[1] = 0;
        repeat (4) tick();

        // D-only 8-word load, then store end with reset_ack on the VALID drop edge.
        v[0] = 1; aal1[0] = 1; mem_ready = 1;
        @(negedge clk); chk("donly_pre", owner, 2'b00);
        @(negedge clk); chk("donly_owner", owner, 2'b01); chk("donly_mem_valid", mem_valid, 1'b1);
        for (int w = 0; w < 8; w++) begin
            tick(); mem_adm = 4'(w); adl1[0] = 4'(w); mem_dmem = $urandom;
            @(negedge clk);
            chk("burst_d_ack", adm_o[0], 4'(w));
            chk("burst_i_idle", adm_o[1], 4'hF);
        end
        tick(); v[0] = 0; ral1[0] = 1; mem_ram = 1;
        @(negedge clk); @(negedge clk);
        chk("store_rel_owner", owner, 2'b00);
        chk("store_rel_mem_valid", mem_valid, 1'b0);
        chk("store_rel_reset_ack_l1", mem_ral1_o, 1'b1);
        chk("store_rel_reset_ack_mem_d", ram_o[0], 1'b1);
        tick(); ral1[0] = 0; mem_ram = 0; mem_adm = 4'hF; adl1[0] = 4'hF;
        repeat (4) tick();

        // Second conflict: D finished last, so I wins.
        v[0] = 1; v[1] = 1;
        @(negedge clk); @(negedge clk); chk("conflict2_i", owner, 2'b10);

        // I completes; D granted and memory stalls.
        tick(); v[1] = 0; mem_aam = 0; mem_acm = 0;
        n = 0;
        while (owner != 2'b01 && n < 20) begin @(negedge clk); n++; end
        chk("stall_d_granted", owner, 2'b01);
        n = 0;
        while (!to_err && n < 400) begin
            @(negedge clk); n++;
            if (n == 10) v[1] = 1;
        end
        chk("timeout_latency", n, 256);
        chk("timeout_err_owner", err_owner, 1'b0);
        @(negedge clk); chk("timeout_pulse_width", to_err, 1'b0); chk("timeout_rel", owner, 2'b00);
        @(negedge clk); chk("timeout_i_granted", owner, 2'b10);
        tick(); v[1] = 0;
        repeat (6) @(negedge clk);
        chk("masked_d", owner, 2'b00);
        tick(); v[0] = 0;
        tick(); v[0] = 1;
        @(negedge clk); @(negedge clk); chk("unmasked_d", owner, 2'b01);

        // Reset mid-burst with I granted.
        tick(); v[0] = 0;
        repeat (4) tick();
        v[1] = 1; mem_ready = 1;
        repeat (3) begin tick(); mem_adm = 4'($urandom); end
        @(negedge clk); chk("prereset_i", owner, 2'b10);
        @(posedge clk); #3 rst_n = 0; #1;
        chk("midrst_owner", owner, 2'b00);
        chk("midrst_mem_valid", mem_valid, 1'b0);
        chk("midrst_i_ready", rdy_o[1], 1'b0);
        chk("midrst_i_ack_data", adm_o[1], 4'hF);
        chk("midrst_mem_ack_data_l1", mem_adl1_o, 4'hF);
        v[0] = 1; v[1] = 1;
        tick(); rst_n = 1;
        @(negedge clk); chk("postrst_pre", owner, 2'b00);
        @(negedge clk); chk("postrst_d", owner, 2'b01);
        tick(); v[0] = 0; v[1] = 0;
        repeat (4) tick();

        // Randomized traffic with occasional frozen windows long enough to trip the watchdog.
        stall_left = 0;
        for (int c = 0; c < 8000; c++) begin
            tick();
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                if ($urandom_range(0, 399) == 0) stall_left = 300;
                for (int k = 0; k < 2; k++) begin
                    if (v[k]) begin
                        if ($urandom_range(0, 11) == 0) v[k] = 0;
                    end else if ($urandom_range(0, 5) == 0) begin
                        v[k] = 1;
                    end
                    dl1[k]  = $urandom;
                    aal1[k] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) adl1[k] = 4'($urandom);
                    acl1[k] = 1'($urandom_range(0, 1));
                    ral1[k] = 1'($urandom_range(0, 1));
                end
                mem_ready = 1'($urandom_range(0, 1));
                mem_dmem  = $urandom;
                if ($urandom_range(0, 2) == 0) mem_adm = 4'($urandom);
                if ($urandom_range(0, 4) == 0) mem_aam = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0) mem_acm = 1'($urandom_range(0, 1));
                mem_ram = 1'($urandom_range(0, 1));
            end
        end

        @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
